// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module   : dmem_arb_pkg
// Desc     : Shared types and constants for the data-memory arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    localparam int DEF_MAX_BURST  = 8;
    localparam int DEF_STARVE_LIM = 4;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick2.sv
// ============================================================================
// Module   : rr_pick2
// Desc     : Combinational 2-way round-robin picker with starvation override.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] starved,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b01) begin
            gnt = 2'b01;
        end else if (req == 2'b10) begin
            gnt = 2'b10;
        end else if (req == 2'b11) begin
            // A lone starved master wins; otherwise alternate away from last.
            if (starved == 2'b01) begin
                gnt = 2'b01;
            end else if (starved == 2'b10) begin
                gnt = 2'b10;
            end else begin
                gnt = last ? 2'b01 : 2'b10;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Desc     : Two-master round-robin arbiter for the single-port data memory,
//            with burst lock and starvation limit. Optional statistics
//            counters are enabled with the macro DMEM_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int STARVE_LIM = DEF_STARVE_LIM
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wd,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rd,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wd,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
`ifdef DMEM_ARB_STATS_EN
    input  logic          stat_clr,
    output logic [31:0]   stat_gnt0,
    output logic [31:0]   stat_gnt1,
    output logic [31:0]   stat_conflict,
`endif
    input  logic [DW-1:0] mem_rd
);

    localparam int c_BW = $clog2(MAX_BURST + 1);
    localparam int c_SW = $clog2(STARVE_LIM + 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    arb_state_t       w_own_tgt;
    logic             r_last;
    logic [c_BW-1:0]  r_burst_cnt;
    logic [c_BW-1:0]  w_burst_nxt;
    logic [1:0]       w_req;
    logic [1:0]       w_we;
    logic [1:0]       w_starved;
    logic [1:0]       w_pick_gnt;
    logic [1:0]       w_gnt;
    logic             w_glock;
    logic [c_SW-1:0]  r_starve [2];
    logic             r_rvalid [2];
    logic [DW-1:0]    r_rd     [2];

    assign w_req = {m1_req, m0_req};
    assign w_we  = {m1_we,  m0_we};

    rr_pick2 u_pick (
        .req     (w_req),
        .last    (r_last),
        .starved (w_starved),
        .gnt     (w_pick_gnt)
    );

    // A lock owner that stops requesting falls back to the normal picker.
    always_comb begin
        w_gnt = w_pick_gnt;
        if (r_state == OWN0 && m0_req) begin
            w_gnt = 2'b01;
        end else if (r_state == OWN1 && m1_req) begin
            w_gnt = 2'b10;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        w_burst_nxt = '0;
        w_glock     = w_gnt[M_DMA] ? m1_lock : m0_lock;
        w_own_tgt   = w_gnt[M_DMA] ? OWN1 : OWN0;
        if ((|w_gnt) && w_glock) begin
            w_burst_nxt = (r_state == w_own_tgt) ? r_burst_cnt + 1'b1 : c_BW'(1);
            if (w_burst_nxt < c_BW'(MAX_BURST)) begin
                w_state_nxt = w_own_tgt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
            if (|w_gnt) begin
                r_last <= w_gnt[M_DMA];
            end
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_master
        assign w_starved[i] = (r_starve[i] == c_SW'(STARVE_LIM));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_starve[i] <= '0;
                r_rvalid[i] <= 1'b0;
                r_rd[i]     <= '0;
            end else begin
                r_rvalid[i] <= w_gnt[i] & ~w_we[i];
                if (w_gnt[i] && !w_we[i]) begin
                    r_rd[i] <= mem_rd;
                end
                if (w_gnt[i]) begin
                    r_starve[i] <= '0;
                end else if (w_req[i] && !w_starved[i]) begin
                    r_starve[i] <= r_starve[i] + 1'b1;
                end
            end
        end
    end

    assign m0_gnt    = w_gnt[M_CPU];
    assign m1_gnt    = w_gnt[M_DMA];
    assign m0_rvalid = r_rvalid[0];
    assign m1_rvalid = r_rvalid[1];
    assign m0_rd     = r_rd[0];
    assign m1_rd     = r_rd[1];

    // Idle cycles present master 0 on the bus with the write strobe low.
    assign mem_addr = w_gnt[M_DMA] ? m1_addr : m0_addr;
    assign mem_wd   = w_gnt[M_DMA] ? m1_wd   : m0_wd;
    assign mem_we   = (w_gnt[M_CPU] & m0_we) | (w_gnt[M_DMA] & m1_we);

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] r_stat_gnt0;
    logic [31:0] r_stat_gnt1;
    logic [31:0] r_stat_conflict;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_gnt0     <= '0;
            r_stat_gnt1     <= '0;
            r_stat_conflict <= '0;
        end else if (stat_clr) begin
            r_stat_gnt0     <= '0;
            r_stat_gnt1     <= '0;
            r_stat_conflict <= '0;
        end else begin
            if (w_gnt[M_CPU] && r_stat_gnt0 != '1) begin
                r_stat_gnt0 <= r_stat_gnt0 + 1'b1;
            end
            if (w_gnt[M_DMA] && r_stat_gnt1 != '1) begin
                r_stat_gnt1 <= r_stat_gnt1 + 1'b1;
            end
            if ((&w_req) && r_stat_conflict != '1) begin
                r_stat_conflict <= r_stat_conflict + 1'b1;
            end
        end
    end

    assign stat_gnt0     = r_stat_gnt0;
    assign stat_gnt1     = r_stat_gnt1;
    assign stat_conflict = r_stat_conflict;
`endif

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-master arbiter sharing the single-port data memory (combinational read, clocked write) between the MIPS core (master 0) and a DMA/debug loader (master 1). Round-robin grant with optional burst lock and a starvation limit. Read data is registered and returned one cycle after grant. Sits between the core/loader and the data memory inside the top-level system.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_BURST, 8, max consecutive grants to a locked master before forced hand-over
STARVE_LIM, 4, cycles a waiting master may be denied before it gets forced priority

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
m0_req  in  1  master 0 access request; held until granted
m0_we  in  1  master 0 write enable (qualified by m0_req)
m0_lock  in  1  master 0 requests burst ownership
m0_addr  in  AW  master 0 byte address
m0_wd  in  DW  master 0 write data
m0_gnt  out  1  master 0 granted this cycle (combinational)
m0_rvalid  out  1  master 0 read data valid (registered)
m0_rd  out  DW  master 0 read data (registered)
m1_*  (same seven ports, same semantics)  master 1
mem_addr  out  AW  memory address, muxed from the granted master
mem_wd  out  DW  memory write data
mem_we  out  1  memory write enable = granted master's we & gnt
mem_rd  in  DW  memory read data (combinational from memory)

Behaviour:
- Reset (reset=0, async): state=IDLE, last=1 (so master 0 wins the first tie), burst_cnt=0, starve0/1=0, m*_rvalid=0, m*_rd=0. Combinational outputs are 0 while no request is present.
- At most one gnt per cycle. gnt is combinational from req and state. Access completes in the granted cycle: the write commits on that clock edge; a read is captured into mX_rd and mX_rvalid=1 on the next cycle only. rvalid lasts exactly one cycle and is 0 for writes.
- States:
  - IDLE: no owner.
  - OWN0: master 0 holds a lock.
  - OWN1: master 1 holds a lock.
- IDLE grant rule:
  - Single requester: that master is granted.
  - Both requesting: the master that was not `last` is granted (round robin), unless a starve counter has reached STARVE_LIM, in which case the starved master is granted.
  - `last` updates on every grant.
- Entering OWNx: on a grant to x with mx_lock=1, burst_cnt=1.
- While in OWNx:
  - x is granted whenever mx_req=1, and burst_cnt increments.
  - Exit to IDLE when lock drops, when req drops with lock still high (no grant that cycle; the other master may be granted), or when burst_cnt reaches MAX_BURST. At MAX_BURST, the next cycle goes to the other master if it is requesting.
- Starve counters:
  - starveX increments each cycle mX_req=1 and gnt=0.
  - It clears on a grant to X.
  - It saturates at STARVE_LIM.
- Address/data mux selects the granted master; when nothing is granted it outputs master 0 values with mem_we=0.
- A reset asserted mid-burst returns to IDLE; a write in that cycle is not guaranteed.

Optional Feature:
Macro: DMEM_ARB_STATS_EN.
- Defined: adds outputs stat_gnt0, stat_gnt1 (32-bit grant counters, saturating), stat_conflict (32-bit count of cycles with both req=1), and stat_clr (input, synchronous clear). All clear on reset.
- Undefined: these ports and their logic are absent.

Decomposition:
- Package dmem_arb_pkg:
  - State encoding typedef (IDLE, OWN0, OWN1).
  - Master index constants M_CPU=0, M_DMA=1.
  - Default MAX_BURST and STARVE_LIM.
- One sub-module, rr_pick2: 2-way round-robin picker with starvation override, combinational.

Test Plan:
- Reset → all outputs 0. m0_req=1 read addr 0x10 → m0_gnt=1 same cycle, m0_rvalid=1 next cycle with mem[0x10].
- Both req, no lock, for 4 cycles → grants alternate 0,1,0,1. m1 write of 0xDEADBEEF to 0x20 is read back by m0 as 0xDEADBEEF.
- m1_lock=1, m1_req held 12 cycles, m0_req=1 throughout → m1 gets 8 consecutive grants, then m0 is granted at cycle 9.
- m0 locks and drops req for 1 cycle while m1 requests → m1 is granted in that cycle and the state returns to IDLE.
- Reset asserted mid-burst (cycle 3 of a lock) → state IDLE, rvalid=0 immediately. After release, the first contended grant goes to m0.
- With DMEM_ARB_STATS_EN: 10 contended cycles → stat_conflict=10 and stat_gnt0+stat_gnt1=10. stat_clr → all counters 0.
